serial_adder_ctrl: RTL and testbench

Bit-serial multi-bit adder controller that sequences a single instance of the team's 1-bit full adder (`adder_1bit`) over `WIDTH` cycles.
- Operands are captured on a start handshake, then shifted LSB-first through the adder with a registered carry.
- The result is published with a one-cycle done pulse.
- Sits between a requester (register file or test controller) and the shared 1-bit adder datapath, trading latency for area.

---
 rtl/serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one adder_1bit over WIDTH cycles, LSB first.
// Optional macro SERIAL_ADDER_OVERFLOW_EN enables registered signed-overflow output.

module adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_cat;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last_bit;

  adder_1bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry_r),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // Result register keeps WIDTH-1 bits; the final bit is merged in on the last edge.
  assign res_cat  = {fa_s, res_sh};
  assign last_bit = (state == ADD) && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      busy <= (state_nxt == ADD);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_r <= carry_in;
            cnt     <= '0;
          end
        end
        ADD: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_cat[WIDTH-1:1];
          carry_r <= fa_c;
          if (last_bit) begin
            sum       <= res_cat;
            carry_out <= fa_c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_r;

  // carry_r holds the carry into the MSB while the last bit is processed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_r <= 1'b0;
    else if (last_bit) ovf_r <= carry_r ^ fa_c;
  end

  assign overflow = ovf_r;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl with an expected-result scoreboard queue.

module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] sum;

  int checks = 0;
  int passed = 0;
  logic [W+1:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Packed as {overflow, carry_out, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    logic [W:0] t;
    logic       ovf;
    t = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf = (av[W-1] == bv[W-1]) && (t[W-1] != av[W-1]);
`else
    ovf = 1'b0;
`endif
    return {ovf, t[W], t[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Called at the negedge before the accepting edge; returns at the negedge after done falls.
  task automatic wait_result(input bit hold, input int poke_k);
    int           k = 0;
    int           busy_cnt = 0;
    bit           stable = 1'b1;
    logic [W-1:0] held = '0;
    logic [W+1:0] e;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        held = sum;
        if (!hold) start = 1'b0;
      end
      if (poke_k != 0 && k == poke_k) begin
        a     = '1;
        b     = '1;
        start = 1'b1;
      end
      if (busy) begin
        busy_cnt++;
        if (sum !== held) stable = 1'b0;
      end
      if (done) break;
    end
    check("latency", k, W + 1);
    check("busy_cycles", busy_cnt, W);
    check("sum_stable", stable, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check("sum", sum, e[W-1:0]);
    check("carry_out", carry_out, e[W]);
    check("overflow", overflow, e[W+1]);
    @(negedge clk);
    check("done_fall", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit hold);
    a        = av;
    b        = bv;
    carry_in = cv;
    start    = 1'b1;
    exp_q.push_back(model(av, bv, cv));
    wait_result(hold, 0);
  endtask

  initial begin
    int done_cnt;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h3C, 8'h21, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);

    // start and new operands during ADD ignored; start held through DONE accepted afterwards
    a        = 8'h10;
    b        = 8'h20;
    carry_in = 1'b0;
    start    = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    wait_result(1'b0, 2);
    exp_q.push_back(model(8'hFF, 8'hFF, 1'b0));
    wait_result(1'b0, 0);

    // reset mid-ADD discards the operation
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", carry_out, 0);
    check("midrst_ovf", overflow, 0);
    rst      = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    // back-to-back with start held continuously
    run_op(8'h12, 8'h34, 1'b0, 1'b1);
    run_op(8'hF0, 8'h0F, 1'b1, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
